// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM encoding, grant encoding and
// the two-way round-robin pick used in IDLE.
package cacheline_arbiter_pkg;

  localparam int LINE_BYTES = 32;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 256;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // When both sides request, the side that did not win last time goes next.
  function automatic grant_t arb_pick(input logic   i_req,
                                      input logic   d_req,
                                      input grant_t last);
    grant_t g;
    g = GNT_I;
    if (i_req && d_req) begin
      if (last == GNT_I) g = GNT_D;
      else               g = GNT_I;
    end else if (d_req) begin
      g = GNT_D;
    end
    return g;
  endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline-adapter port between the I-cache and D-cache, one
// whole-line transaction at a time, with round-robin between the two.
//
//  state        | meaning
//  ARB_IDLE     | no transaction; pick a requester, latch its addr/op/data
//  ARB_SERVE_I  | I-fill in flight on the adapter; wait for mem_resp
//  ARB_SERVE_D  | D-fill or writeback in flight; wait for mem_resp
module cacheline_arbiter
  import cacheline_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q;
  grant_t            last_grant_q;
  grant_t            grant_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              i_req;
  logic              d_req;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_d = arb_pick(i_req, d_req, last_grant_q);

  // Requests are only looked at in IDLE; while serving, everything comes from
  // the copies latched at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GNT_I;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            last_grant_q <= grant_d;
            if (grant_d == GNT_D) begin
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              // read+write together is illegal; the write wins
              mem_write_q <= d_write;
              mem_read_q  <= ~d_write;
              state_q     <= ARB_SERVE_D;
            end else begin
              mem_addr_q  <= i_addr;
              mem_write_q <= 1'b0;
              mem_read_q  <= 1'b1;
              state_q     <= ARB_SERVE_I;
            end
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= ARB_IDLE;
          end
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

  assign i_resp  = (state_q == ARB_SERVE_I) && mem_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write))
        else $warning("d_read and d_write both high; treated as write");
      assert (!(mem_resp && state_q == ARB_IDLE))
        else $warning("mem_resp seen while IDLE; ignored");
      assert (!(state_q == ARB_IDLE && d_req && d_addr[LINE_OFF_W-1:0] != '0))
        else $warning("d_addr not line aligned");
      assert (!(state_q == ARB_IDLE && i_req && i_addr[LINE_OFF_W-1:0] != '0))
        else $warning("i_addr not line aligned");
      assert (!(mem_read_q && mem_write_q))
        else $error("mem_read and mem_write high together");
      assert (!(i_resp && d_resp))
        else $error("i_resp and d_resp high together");
    end
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: reset, lone fill, writeback,
// mid-service input change, round-robin contention and a stray mem_resp.
module tb_cacheline_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic [AW-1:0] i_addr;
  logic          i_read;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic [AW-1:0] d_addr;
  logic          d_read;
  logic          d_write;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int n_checks = 0;
  int n_pass   = 0;

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (i_addr),
    .i_read    (i_read),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_addr    (d_addr),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [LW-1:0] pat_a;
  logic [LW-1:0] pat_5;
  logic [AW-1:0] exp_addr;
  logic          exp_d;

  initial begin
    pat_a     = {32{8'hAA}};
    pat_5     = {32{8'h55}};
    rst       = 1'b0;
    i_addr    = '0;
    i_read    = 1'b0;
    d_addr    = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    tick();
    tick();
    chk("rst_mem_read",  LW'(mem_read),  LW'(0));
    chk("rst_mem_write", LW'(mem_write), LW'(0));
    chk("rst_mem_addr",  LW'(mem_addr),  LW'(0));
    chk("rst_mem_wdata", mem_wdata,      LW'(0));
    chk("rst_i_resp",    LW'(i_resp),    LW'(0));
    chk("rst_d_resp",    LW'(d_resp),    LW'(0));
    rst = 1'b1;
    tick();

    // reset in the middle of a writeback drops mem_write immediately
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = pat_a;
    tick();
    chk("rstmid_write_up", LW'(mem_write), LW'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_write_low", LW'(mem_write), LW'(0));
    chk("rstmid_read_low",  LW'(mem_read),  LW'(0));
    d_write = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_idle_read",  LW'(mem_read),  LW'(0));
    chk("rstmid_idle_write", LW'(mem_write), LW'(0));

    // lone I miss, plus i_addr changing mid-service
    i_read = 1'b1;
    i_addr = 32'h6000_0020;
    tick();
    chk("i_mem_read",  LW'(mem_read),  LW'(1));
    chk("i_mem_write", LW'(mem_write), LW'(0));
    chk("i_mem_addr",  LW'(mem_addr),  LW'(32'h6000_0020));
    i_addr = 32'h6000_0040;
    tick();
    chk("i_addr_held",  LW'(mem_addr), LW'(32'h6000_0020));
    chk("i_read_held",  LW'(mem_read), LW'(1));
    chk("i_no_resp_yet", LW'(i_resp),  LW'(0));
    mem_resp  = 1'b1;
    mem_rdata = pat_a;
    #1;
    chk("i_resp",  LW'(i_resp), LW'(1));
    chk("i_rdata", i_rdata,     pat_a);
    chk("i_dresp", LW'(d_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    chk("i_done_read", LW'(mem_read), LW'(0));
    chk("i_done_resp", LW'(i_resp),   LW'(0));
    tick();

    // writeback
    d_write = 1'b1;
    d_addr  = 32'h0000_1000;
    d_wdata = pat_5;
    tick();
    chk("wb_mem_write", LW'(mem_write), LW'(1));
    chk("wb_mem_read",  LW'(mem_read),  LW'(0));
    chk("wb_mem_addr",  LW'(mem_addr),  LW'(32'h0000_1000));
    chk("wb_mem_wdata", mem_wdata,      pat_5);
    tick();
    chk("wb_mem_read2", LW'(mem_read),  LW'(0));
    chk("wb_write2",    LW'(mem_write), LW'(1));
    mem_resp = 1'b1;
    #1;
    chk("wb_d_resp", LW'(d_resp), LW'(1));
    chk("wb_i_resp", LW'(i_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    d_write  = 1'b0;
    chk("wb_done_write", LW'(mem_write), LW'(0));
    chk("wb_done_read",  LW'(mem_read),  LW'(0));
    tick();

    // contention from reset: last_grant=I, so D,I,D,I
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    i_read = 1'b1;
    i_addr = 32'h6000_0100;
    d_read = 1'b1;
    d_addr = 32'h0000_3000;
    for (int k = 0; k < 4; k++) begin
      exp_d    = (k % 2 == 0);
      exp_addr = exp_d ? 32'h0000_3000 : 32'h6000_0100;
      tick();
      chk($sformatf("rr%0d_mem_read", k), LW'(mem_read), LW'(1));
      chk($sformatf("rr%0d_mem_addr", k), LW'(mem_addr), LW'(exp_addr));
      mem_resp  = 1'b1;
      mem_rdata = LW'(k + 1);
      #1;
      chk($sformatf("rr%0d_i_resp", k), LW'(i_resp), LW'(!exp_d));
      chk($sformatf("rr%0d_d_resp", k), LW'(d_resp), LW'(exp_d));
      chk($sformatf("rr%0d_rdata", k), exp_d ? d_rdata : i_rdata, LW'(k + 1));
      tick();
      mem_resp = 1'b0;
      chk($sformatf("rr%0d_gap", k), LW'(mem_read), LW'(0));
    end
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    tick();

    // stray mem_resp while IDLE
    mem_resp = 1'b1;
    #1;
    chk("spur_i_resp", LW'(i_resp), LW'(0));
    chk("spur_d_resp", LW'(d_resp), LW'(0));
    tick();
    mem_resp = 1'b0;
    chk("spur_mem_read",  LW'(mem_read),  LW'(0));
    chk("spur_mem_write", LW'(mem_write), LW'(0));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
